// File: rtl/risc_pkg.sv
// Shared definitions for the RISC core instruction sequencer: opcode values,
// controller state encoding and opcode classification helpers.
package risc_pkg;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [3:0] {
    S_F_ADDR = 4'd0,
    S_F_RD   = 4'd1,
    S_F_LD   = 4'd2,
    S_DECODE = 4'd3,
    S_O_ADDR = 4'd4,
    S_O_RD   = 4'd5,
    S_EXEC   = 4'd6,
    S_WB     = 4'd7,
    S_HALTED = 4'd8
  } state_t;

  // Opcodes that fetch an operand from memory into the accumulator path.
  function automatic logic is_rd_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Watchdog for memory handshake waits: counts not-ready cycles and flags when
// the next not-ready cycle would exceed the allowed limit.
module mem_wait_timer #(
  parameter int unsigned TMO_LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CNT_W = (TMO_LIMIT > 1) ? $clog2(TMO_LIMIT) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'((TMO_LIMIT > 0) ? TMO_LIMIT - 1 : 0);

  logic [CNT_W-1:0] r_cnt;

  // Count not-ready cycles; saturate at the terminal value so the counter
  // never wraps even if the caller keeps ticking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (tick && (TMO_LIMIT != 0) && (r_cnt != TERM)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = (TMO_LIMIT != 0) && (r_cnt == TERM);

endmodule

// File: rtl/seq_controller.sv
// Multi-cycle instruction sequencer for the simple RISC core. Walks each
// opcode through only the phases it needs, waits on mem_ready in memory
// phases, parks in a resumable halt state and counts retired instructions.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// F_ADDR   | drive PC onto the address bus for instruction fetch
// F_RD     | instruction read in flight, wait for mem_ready
// F_LD     | latch instruction into IR
// DECODE   | bump PC, route by opcode (halt on HLT / illegal)
// O_ADDR   | drive IR operand address onto the bus
// O_RD     | operand read in flight, wait for mem_ready
// EXEC     | execute: load AC, conditional skip, jump or drive store data
// WB       | store write in flight, wait for mem_ready
// HALTED   | parked; resume leaves unless a fault flag is set
module seq_controller
  import risc_pkg::*;
#(
  parameter int unsigned OPC_W     = 3,
  parameter int unsigned RETIRE_W  = 16,
  parameter int unsigned TMO_LIMIT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPC_W-1:0]    opcode,
  input  logic                zero,
  input  logic                mem_ready,
  input  logic                resume,
  output logic                sel,
  output logic                rd,
  output logic                ld_ir,
  output logic                halt,
  output logic                inc_pc,
  output logic                ld_ac,
  output logic                ld_pc,
  output logic                wr,
  output logic                data_e,
  output logic                illegal,
  output logic                timeout,
  output logic [RETIRE_W-1:0] retired
);

  state_t              r_state;
  logic                r_illegal;
  logic                r_timeout;
  logic [RETIRE_W-1:0] r_retired;

  logic [2:0] w_op;
  logic       w_op_illegal;
  logic       w_in_wait;
  logic       w_expired;
  logic       w_tmo;
  logic       w_retire;

  assign w_op         = opcode[2:0];
  assign w_op_illegal = (32'(opcode) > 32'd7);
  assign w_in_wait    = (r_state == S_F_RD) || (r_state == S_O_RD) || (r_state == S_WB);
  assign w_tmo        = w_in_wait && !mem_ready && w_expired;
  assign w_retire     = ((r_state == S_EXEC) && (w_op != OP_STO)) ||
                        ((r_state == S_WB) && mem_ready);

  // Counter is held clear outside wait states; wait states are never
  // back-to-back, so every wait starts from zero.
  mem_wait_timer #(
    .TMO_LIMIT(TMO_LIMIT)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (!w_in_wait),
    .tick   (w_in_wait && !mem_ready),
    .expired(w_expired)
  );

  // Sequencer state and sticky fault flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_F_ADDR;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_F_ADDR: r_state <= S_F_RD;
        S_F_RD: begin
          if (mem_ready) begin
            r_state <= S_F_LD;
          end else if (w_tmo) begin
            r_state   <= S_HALTED;
            r_timeout <= 1'b1;
          end
        end
        S_F_LD: r_state <= S_DECODE;
        S_DECODE: begin
          if (w_op_illegal) begin
            r_state   <= S_HALTED;
            r_illegal <= 1'b1;
          end else if (w_op == OP_HLT) begin
            r_state <= S_HALTED;
          end else if ((w_op == OP_SKZ) || (w_op == OP_JMP)) begin
            r_state <= S_EXEC;
          end else begin
            r_state <= S_O_ADDR;
          end
        end
        S_O_ADDR: begin
          if (is_rd_op(w_op)) begin
            r_state <= S_O_RD;
          end else if (w_op == OP_STO) begin
            r_state <= S_EXEC;
          end else begin
            r_state <= S_F_ADDR;
          end
        end
        S_O_RD: begin
          if (mem_ready) begin
            r_state <= S_EXEC;
          end else if (w_tmo) begin
            r_state   <= S_HALTED;
            r_timeout <= 1'b1;
          end
        end
        S_EXEC: r_state <= (w_op == OP_STO) ? S_WB : S_F_ADDR;
        S_WB: begin
          if (mem_ready) begin
            r_state <= S_F_ADDR;
          end else if (w_tmo) begin
            r_state   <= S_HALTED;
            r_timeout <= 1'b1;
          end
        end
        S_HALTED: begin
          if (resume && !r_illegal && !r_timeout) begin
            r_state <= S_F_ADDR;
          end
        end
        default: r_state <= S_F_ADDR;
      endcase
    end
  end

  // Retired-instruction counter, wraps naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + 1'b1;
    end
  end

  // Moore strobe decode from registered state; EXEC also looks at opcode/zero.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    halt   = 1'b0;
    inc_pc = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    case (r_state)
      S_F_ADDR: sel = 1'b1;
      S_F_RD: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      S_F_LD: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      S_DECODE: begin
        sel    = 1'b1;
        inc_pc = 1'b1;
      end
      S_O_RD: rd = 1'b1;
      S_EXEC: begin
        if (is_rd_op(w_op)) begin
          rd    = 1'b1;
          ld_ac = 1'b1;
        end else if (w_op == OP_SKZ) begin
          inc_pc = zero;
        end else if (w_op == OP_JMP) begin
          ld_pc = 1'b1;
        end else if (w_op == OP_STO) begin
          data_e = 1'b1;
        end
      end
      S_WB: begin
        data_e = 1'b1;
        wr     = 1'b1;
      end
      S_HALTED: begin
        halt = 1'b1;
        sel  = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal = r_illegal;
  assign timeout = r_timeout;
  assign retired = r_retired;

endmodule

// File: tb/tb_seq_controller.sv
// Self-checking bench for seq_controller: directed and randomized instruction
// streams compared cycle by cycle against a phase-list model of each opcode.
module tb_seq_controller;

  localparam int TMO = 15;
  // phase tags used by the model
  localparam int P_FA = 0, P_FR = 1, P_FL = 2, P_DEC = 3, P_OA = 4,
                 P_OR = 5, P_EX = 6, P_WB = 7, P_HALT = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1_n, rst2_n, zero, mem_ready, resume;
  logic [2:0] opcode1;
  logic [3:0] opcode2;

  logic sel1, rd1, ld_ir1, halt1, inc_pc1, ld_ac1, ld_pc1, wr1, data_e1, illegal1, timeout1;
  logic sel2, rd2, ld_ir2, halt2, inc_pc2, ld_ac2, ld_pc2, wr2, data_e2, illegal2, timeout2;
  logic [15:0] retired1;
  logic [1:0]  retired2;

  seq_controller u1 (
    .clk(clk), .rst_n(rst1_n), .opcode(opcode1), .zero(zero), .mem_ready(mem_ready),
    .resume(resume), .sel(sel1), .rd(rd1), .ld_ir(ld_ir1), .halt(halt1), .inc_pc(inc_pc1),
    .ld_ac(ld_ac1), .ld_pc(ld_pc1), .wr(wr1), .data_e(data_e1), .illegal(illegal1),
    .timeout(timeout1), .retired(retired1)
  );

  seq_controller #(.OPC_W(4), .RETIRE_W(2)) u2 (
    .clk(clk), .rst_n(rst2_n), .opcode(opcode2), .zero(zero), .mem_ready(mem_ready),
    .resume(resume), .sel(sel2), .rd(rd2), .ld_ir(ld_ir2), .halt(halt2), .inc_pc(inc_pc2),
    .ld_ac(ld_ac2), .ld_pc(ld_pc2), .wr(wr2), .data_e(data_e2), .illegal(illegal2),
    .timeout(timeout2), .retired(retired2)
  );

  int errors = 0;
  int checks = 0;
  int ret1 = 0;
  int ret2 = 0;
  int ph_q[$];
  bit rdy_q[$];
  bit to_flag;

  // {sel,rd,ld_ir,halt,inc_pc,ld_ac,ld_pc,wr,data_e}
  function automatic logic [8:0] got(input int which);
    if (which == 0)
      return {sel1, rd1, ld_ir1, halt1, inc_pc1, ld_ac1, ld_pc1, wr1, data_e1};
    return {sel2, rd2, ld_ir2, halt2, inc_pc2, ld_ac2, ld_pc2, wr2, data_e2};
  endfunction

  function automatic logic [8:0] exp_strobes(input int ph, input int opc, input bit z);
    case (ph)
      P_FA:   return 9'b1_0000_0000;
      P_FR:   return 9'b1_1000_0000;
      P_FL:   return 9'b1_1100_0000;
      P_DEC:  return 9'b1_0001_0000;
      P_OA:   return 9'b0_0000_0000;
      P_OR:   return 9'b0_1000_0000;
      P_EX: begin
        if (opc >= 2 && opc <= 5) return 9'b0_1000_1000;
        if (opc == 1)             return {4'b0000, z, 4'b0000};
        if (opc == 7)             return 9'b0_0000_0100;
        if (opc == 6)             return 9'b0_0000_0001;
        return 9'b0;
      end
      P_WB:   return 9'b0_0000_0011;
      P_HALT: return 9'b1_0010_0000;
      default: return 9'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add(input int ph, input bit rdy);
    if (!to_flag) begin
      ph_q.push_back(ph);
      rdy_q.push_back(rdy);
    end
  endtask

  task automatic add_wait(input int ph, input int w);
    if (to_flag) return;
    if (w >= TMO) begin
      for (int k = 0; k < TMO; k++) add(ph, 1'b0);
      to_flag = 1'b1;
    end else begin
      for (int k = 0; k < w; k++) add(ph, 1'b0);
      add(ph, 1'b1);
    end
  endtask

  task automatic chk_retired(input int which, input string tag);
    if (which == 0) chk(tag, 32'(retired1), 32'(ret1 % 65536));
    else            chk(tag, 32'(retired2), 32'(ret2 % 4));
  endtask

  // Run one instruction from F_ADDR; wf/wo/ww are not-ready cycles in each wait.
  task automatic run_instr(input int which, input int opc, input bit z,
                           input int wf, input int wo, input int ww);
    ph_q.delete();
    rdy_q.delete();
    to_flag = 1'b0;
    add(P_FA, 1'($urandom_range(0, 1)));
    add_wait(P_FR, wf);
    add(P_FL, 1'($urandom_range(0, 1)));
    add(P_DEC, 1'($urandom_range(0, 1)));
    if (opc == 1 || opc == 7) begin
      add(P_EX, 1'($urandom_range(0, 1)));
    end else if (opc >= 2 && opc <= 6) begin
      add(P_OA, 1'($urandom_range(0, 1)));
      if (opc != 6) add_wait(P_OR, wo);
      add(P_EX, 1'($urandom_range(0, 1)));
      if (opc == 6) add_wait(P_WB, ww);
    end
    opcode1 = opc[2:0];
    opcode2 = opc[3:0];
    zero    = z;
    resume  = 1'b0;
    for (int i = 0; i < ph_q.size(); i++) begin
      chk($sformatf("strobes u%0d op%0d ph%0d cyc%0d", which, opc, ph_q[i], i),
          32'(got(which)), 32'(exp_strobes(ph_q[i], opc, z)));
      mem_ready = rdy_q[i];
      @(posedge clk);
      #1;
    end
    if (opc >= 1 && opc <= 7 && !to_flag) begin
      if (which == 0) ret1++;
      else            ret2++;
    end
    chk_retired(which, $sformatf("retired u%0d op%0d", which, opc));
  endtask

  initial begin
    rst1_n = 1'b0; rst2_n = 1'b0;
    zero = 1'b0; mem_ready = 1'b0; resume = 1'b0;
    opcode1 = '0; opcode2 = '0;
    #2;
    chk("reset strobes u1", 32'(got(0)), 32'(exp_strobes(P_FA, 0, 0)));
    chk("reset retired u1", 32'(retired1), 32'd0);
    chk("reset illegal u1", 32'(illegal1), 32'd0);
    chk("reset timeout u1", 32'(timeout1), 32'd0);
    chk("reset strobes u2", 32'(got(1)), 32'(exp_strobes(P_FA, 0, 0)));

    @(posedge clk); #1;
    rst1_n = 1'b1;

    // LDA, ADD, STO, JMP with memory always ready
    run_instr(0, 5, 0, 0, 0, 0);
    run_instr(0, 2, 0, 0, 0, 0);
    run_instr(0, 6, 0, 0, 0, 0);
    run_instr(0, 7, 0, 0, 0, 0);
    chk("retired after four", 32'(retired1), 32'd4);

    // SKZ taken / not taken
    run_instr(0, 1, 1, 0, 0, 0);
    run_instr(0, 1, 0, 0, 0, 0);

    // LDA with 3 not-ready operand cycles
    run_instr(0, 5, 0, 0, 3, 0);

    // randomized instruction stream with short waits
    for (int n = 0; n < 30; n++) begin
      run_instr(0, int'($urandom_range(1, 7)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
    end

    // HLT, resume on the fifth halted cycle
    run_instr(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("halted cyc%0d", k), 32'(got(0)), 32'(exp_strobes(P_HALT, 0, 0)));
      resume = (k == 4);
      @(posedge clk); #1;
    end
    resume = 1'b0;
    chk("after resume", 32'(got(0)), 32'(exp_strobes(P_FA, 0, 0)));
    chk_retired(0, "retired after HLT");

    // LDA timing out in O_RD
    run_instr(0, 5, 0, 0, 15, 0);
    chk("timeout flag", 32'(timeout1), 32'd1);
    chk("illegal flag clear", 32'(illegal1), 32'd0);
    resume = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("timeout resume ignored %0d", k), 32'(got(0)), 32'(exp_strobes(P_HALT, 0, 0)));
      @(posedge clk); #1;
    end
    resume = 1'b0;

    // asynchronous reset mid-cycle
    #3;
    rst1_n = 1'b0;
    #1;
    ret1 = 0;
    chk("async reset strobes u1", 32'(got(0)), 32'(exp_strobes(P_FA, 0, 0)));
    chk("async reset timeout u1", 32'(timeout1), 32'd0);
    chk("async reset retired u1", 32'(retired1), 32'd0);

    // second instance: 2-bit retired counter wraps, 4-bit opcode
    @(posedge clk); #1;
    rst2_n = 1'b1;
    for (int n = 0; n < 5; n++) run_instr(1, 7, 0, 0, 0, 0);
    chk("retired wrap", 32'(retired2), 32'd1);

    run_instr(1, 9, 0, 0, 0, 0);
    chk("illegal flag", 32'(illegal2), 32'd1);
    resume = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("illegal resume ignored %0d", k), 32'(got(1)), 32'(exp_strobes(P_HALT, 0, 0)));
      @(posedge clk); #1;
    end
    resume = 1'b0;
    #3;
    rst2_n = 1'b0;
    #1;
    chk("async reset strobes u2", 32'(got(1)), 32'(exp_strobes(P_FA, 0, 0)));
    chk("async reset illegal u2", 32'(illegal2), 32'd0);
    chk("async reset retired u2", 32'(retired2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
